// File: rtl/adq_pkg.sv
// Shared types and constants for the temperature acquisition block:
// FSM states, sensor frame layout and the accept/reject rule.
package adq_pkg;

  typedef enum logic [2:0] {
    REPOSO,
    ESPERA,
    SELECCION,
    DESPLAZA,
    CIERRE
  } estado_t;

  // Frame layout: [15:14] sync, [13:3] temperature, [2:1] reserved, [0] parity
  localparam int FRAME_W = 16;
  localparam int SYNC_HI = 15;
  localparam int SYNC_LO = 14;
  localparam int TEMP_HI = 13;
  localparam int TEMP_LO = 3;
  localparam int PAR_BIT = 0;
  localparam int TEMP_W  = TEMP_HI - TEMP_LO + 1;

  localparam logic [1:0] SYNC = 2'b10;

  // 1250 does not fit in 11 signed bits, so the upper bound is carried with
  // one extra bit; on an 11-bit field it can never reject anything.
  localparam logic signed [TEMP_W-1:0] TEMP_MIN = -11'sd400;
  localparam logic signed [TEMP_W:0]   TEMP_MAX = 12'sd1250;

  function automatic logic [TEMP_W-1:0] frame_temp(input logic [FRAME_W-1:0] f);
    return f[TEMP_HI:TEMP_LO];
  endfunction

  // Sync, even parity over [15:1] and temperature range must all hold.
  function automatic logic frame_ok(input logic [FRAME_W-1:0] f);
    logic signed [TEMP_W:0] t;
    logic signed [TEMP_W:0] tmin;
    logic                   par;
    t    = $signed({f[TEMP_HI], f[TEMP_HI:TEMP_LO]});
    tmin = $signed({TEMP_MIN[TEMP_W-1], TEMP_MIN});
    par  = ^f[SYNC_HI:PAR_BIT+1];
    return (f[SYNC_HI:SYNC_LO] == SYNC) && (par == f[PAR_BIT]) &&
           (t >= tmin) && (t <= TEMP_MAX);
  endfunction

  // Sign-extend a temperature to the width of a 4-tap sum.
  function automatic logic signed [TEMP_W+1:0] sx(input logic [TEMP_W-1:0] v);
    return $signed({{2{v[TEMP_W-1]}}, v});
  endfunction

endpackage

// File: rtl/adq_gen_sclk.sv
// Serial clock generator: low half first, DIV_SCLK clk cycles per half,
// with single-cycle strobes flagging the clk edge where sclk rises/falls.
module adq_gen_sclk #(
  parameter int DIV_SCLK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk_o,
  output logic sube_o,
  output logic baja_o
);

  localparam int CW = (DIV_SCLK > 2) ? $clog2(DIV_SCLK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_SCLK - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          ultimo;

  assign ultimo = (cnt_q == CNT_LAST);
  assign sclk_o = sclk_q;
  assign sube_o = en && ultimo && !sclk_q;
  assign baja_o = en && ultimo && sclk_q;

  // Half-period count; held at zero (sclk low) whenever not shifting
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (ultimo) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // Counter and sclk level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/adquisicion_temp.sv
// Periodic SPI-mode-0 read of a digital temperature sensor. Each frame is
// checked (sync, parity, range) and either published on temp_salida with a
// temp_valida pulse or dropped with an error_trama pulse.
// Optional build macro ADQ_PROMEDIO_EN: temp_salida becomes a 4-sample
// moving average of accepted samples instead of the latest raw sample.
module adquisicion_temp
  import adq_pkg::*;
#(
  parameter int DIV_SCLK        = 4,
  parameter int PERIODO_MUESTRA = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     habilitar,
  input  logic                     miso_i,
  output logic                     sclk_o,
  output logic                     cs_n_o,
  output logic signed [TEMP_W-1:0] temp_salida,
  output logic                     temp_valida,
  output logic                     error_trama
);

  if (DIV_SCLK < 2) begin : g_chk_div
    $error("DIV_SCLK must be at least 2");
  end
  if (PERIODO_MUESTRA < 33 * DIV_SCLK + 4) begin : g_chk_per
    $error("PERIODO_MUESTRA too short for a full frame");
  end

  localparam int TW = $clog2(PERIODO_MUESTRA);
  localparam logic [TW-1:0] PER_LAST = TW'(PERIODO_MUESTRA - 1);
  localparam logic [TW-1:0] SEL_LAST = TW'(DIV_SCLK - 1);

  estado_t               estado_q, estado_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_W-1:0]    shift_q, shift_d;
  logic                  cs_n_q, cs_n_d;
  logic [TEMP_W-1:0]     temp_q, temp_d;
  logic                  valida_q, valida_d;
  logic                  error_q, error_d;

  logic                  sube, baja;
  logic                  acepta;
  logic [TEMP_W-1:0]     muestra;
  logic [TEMP_W-1:0]     salida;

  adq_gen_sclk #(.DIV_SCLK(DIV_SCLK)) u_sclk (
    .clk    (clk),
    .rst    (rst),
    .en     (estado_q == DESPLAZA),
    .sclk_o (sclk_o),
    .sube_o (sube),
    .baja_o (baja)
  );

  assign muestra     = frame_temp(shift_q);
  assign acepta      = (estado_q == CIERRE) && frame_ok(shift_q);
  assign cs_n_o      = cs_n_q;
  assign temp_salida = temp_q;
  assign temp_valida = valida_q;
  assign error_trama = error_q;

  // Next-state logic; a frame in flight always runs to CIERRE
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      REPOSO:    if (habilitar) estado_d = SELECCION;
      ESPERA: begin
        if (!habilitar)             estado_d = REPOSO;
        else if (timer_q == PER_LAST) estado_d = SELECCION;
      end
      SELECCION: if (timer_q == SEL_LAST) estado_d = DESPLAZA;
      DESPLAZA:  if (baja && (bit_q == 4'd15)) estado_d = CIERRE;
      CIERRE:    estado_d = habilitar ? ESPERA : REPOSO;
      default:   estado_d = REPOSO;
    endcase
  end

  // Period timer: zero on the first SELECCION cycle, saturates at the period
  always_comb begin
    timer_d = timer_q;
    if ((estado_d == SELECCION) && (estado_q != SELECCION))
      timer_d = '0;
    else if (timer_q != PER_LAST)
      timer_d = timer_q + 1'b1;
  end

  // Shift in miso on sclk rises, count completed sclk periods on falls
  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    if (estado_q == SELECCION) begin
      bit_d = '0;
    end else if (estado_q == DESPLAZA) begin
      if (sube) shift_d = {shift_q[FRAME_W-2:0], miso_i};
      if (baja) bit_d   = bit_q + 1'b1;
    end
  end

`ifdef ADQ_PROMEDIO_EN
  logic [2:0][TEMP_W-1:0]  tap_q, tap_d;
  logic                    lleno_q, lleno_d;
  logic signed [TEMP_W+1:0] suma;

  // Window = new sample plus the three previous accepted ones; the first
  // accepted sample after reset fills every tap. Floor divide by 4.
  always_comb begin
    tap_d   = tap_q;
    lleno_d = lleno_q;
    if (lleno_q)
      suma = sx(muestra) + sx(tap_q[0]) + sx(tap_q[1]) + sx(tap_q[2]);
    else
      suma = $signed({muestra, 2'b00});
    if (acepta) begin
      tap_d   = lleno_q ? {tap_q[1], tap_q[0], muestra} : {3{muestra}};
      lleno_d = 1'b1;
    end
    salida = suma[TEMP_W+1:2];
  end

  // Averaging window registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q   <= '0;
      lleno_q <= 1'b0;
    end else begin
      tap_q   <= tap_d;
      lleno_q <= lleno_d;
    end
  end
`else
  assign salida = muestra;
`endif

  // Registered outputs: chip select follows the next state, result pulses
  // land the cycle after CIERRE
  always_comb begin
    cs_n_d   = !((estado_d == SELECCION) || (estado_d == DESPLAZA));
    temp_d   = temp_q;
    valida_d = 1'b0;
    error_d  = 1'b0;
    if (estado_q == CIERRE) begin
      if (acepta) begin
        valida_d = 1'b1;
        temp_d   = salida;
      end else begin
        error_d  = 1'b1;
      end
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= REPOSO;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      cs_n_q   <= 1'b1;
      temp_q   <= '0;
      valida_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      cs_n_q   <= cs_n_d;
      temp_q   <= temp_d;
      valida_q <= valida_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_adquisicion_temp.sv
// Bench for adquisicion_temp: sensor model drives frames, a reference model
// predicts each result into a queue, a monitor checks every output pulse.
`timescale 1ns/1ps
module tb_adquisicion_temp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        habilitar = 1'b0;
  logic        miso_i = 1'b0;
  logic        sclk_o, cs_n_o, temp_valida, error_trama;
  logic [10:0] temp_salida;

  adquisicion_temp dut (
    .clk         (clk),
    .rst         (rst),
    .habilitar   (habilitar),
    .miso_i      (miso_i),
    .sclk_o      (sclk_o),
    .cs_n_o      (cs_n_o),
    .temp_salida (temp_salida),
    .temp_valida (temp_valida),
    .error_trama (error_trama)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               ok;
    logic signed [31:0] temp;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] dir_q[$];
  int vectors = 0, miscompares = 0;
  int npulse = 0, nfall = 0;
  bit chk_period = 1'b1;

  // reference model state
  int last_temp = 0;
  int win[4];
  bit primed = 1'b0;

  function automatic int floor4(input int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  function automatic exp_t model(input logic [15:0] f);
    exp_t e;
    int   t;
    t    = int'($signed(f[13:3]));
    e.ok = (f[15:14] == 2'b10) && ($countones(f) % 2 == 0) && (t >= -400) && (t <= 1250);
    if (e.ok) begin
`ifdef ADQ_PROMEDIO_EN
      if (!primed) win = '{t, t, t, t};
      else         win = '{t, win[0], win[1], win[2]};
      primed    = 1'b1;
      last_temp = floor4(win[0] + win[1] + win[2] + win[3]);
`else
      last_temp = t;
`endif
    end
    e.temp = last_temp;
    return e;
  endfunction

  function automatic logic [15:0] mk(input int t, input logic [1:0] sync, input bit bad);
    logic [15:0] f;
    logic [10:0] tt;
    tt   = 11'(t);
    f    = {sync, tt, 2'($urandom), 1'b0};
    f[0] = (^f[15:1]) ^ bad;
    return f;
  endfunction

  // Sensor: first bit when CS falls, next bit after each sclk fall
  logic [15:0] cur = '0;
  int          idx = 0;
  always @(negedge cs_n_o) begin
    if (dir_q.size() > 0) cur = dir_q.pop_front();
    else cur = mk(int'($urandom_range(1800)) - 500,
                  ($urandom_range(7) == 0) ? 2'($urandom) : 2'b10,
                  $urandom_range(7) == 0);
    exp_q.push_back(model(cur));
    idx = 15;
    #1 miso_i = cur[15];
  end
  always @(negedge sclk_o) begin
    if (!cs_n_o && idx > 0) begin
      idx--;
      #1 miso_i = cur[idx];
    end
  end

  // Monitor: checks pulses against the queue and CS timing
  int   cyc = 0, last_fall = -1, fall_cyc = 0;
  logic cs_prev = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      if (temp_valida || error_trama) begin
        npulse++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse: valida=%b error=%b temp=%0d, none expected",
                   temp_valida, error_trama, $signed(temp_salida));
        end else begin
          e = exp_q.pop_front();
          if (temp_valida !== e.ok || error_trama !== !e.ok || temp_salida !== 11'(e.temp)) begin
            miscompares++;
            $display("FAIL result: got valida=%b error=%b temp=%0d, want valida=%b error=%b temp=%0d",
                     temp_valida, error_trama, $signed(temp_salida), e.ok, !e.ok, e.temp);
          end
        end
      end
      if (cs_prev === 1'b1 && cs_n_o === 1'b0) begin
        nfall++;
        if (chk_period && last_fall >= 0) begin
          vectors++;
          if (cyc - last_fall != 1000) begin
            miscompares++;
            $display("FAIL cs_period: got %0d cycles, want 1000", cyc - last_fall);
          end
        end
        last_fall = cyc;
        fall_cyc  = cyc;
      end
      if (cs_prev === 1'b0 && cs_n_o === 1'b1 && chk_period) begin
        vectors++;
        if (cyc - fall_cyc != 132) begin
          miscompares++;
          $display("FAIL cs_low: got %0d cycles, want 132", cyc - fall_cyc);
        end
      end
    end
    cs_prev = cs_n_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_pulses(input int target, input int budget, input string name);
    int n = 0;
    while (npulse < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(name, 32'(npulse >= target), 32'd1);
  endtask

  task automatic wait_cs_fall(input int budget);
    int n = 0;
    int f0 = nfall;
    while (nfall == f0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1 chk("cs_fall_timeout", 32'(nfall != f0), 32'd1);
  endtask

  task automatic wait_sclk_rises(input int k);
    int   r = 0, n = 0;
    logic p;
    p = sclk_o;
    while (r < k && n < 500) begin
      @(posedge clk);
      #1;
      if (!p && sclk_o) r++;
      p = sclk_o;
      n++;
    end
    chk("sclk_rise_timeout", 32'(r), 32'(k));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cs_n"},   32'(cs_n_o), 32'd1);
    chk({tag, "_sclk"},   32'(sclk_o), 32'd0);
    chk({tag, "_temp"},   32'(temp_salida), 32'd0);
    chk({tag, "_valida"}, 32'(temp_valida), 32'd0);
    chk({tag, "_error"},  32'(error_trama), 32'd0);
  endtask

  initial begin
    int p0, f0;
    // moving-average sequence, then directed accept/reject and range edges
    dir_q.push_back(mk(200, 2'b10, 0));
    dir_q.push_back(mk(200, 2'b10, 0));
    dir_q.push_back(mk(200, 2'b10, 0));
    dir_q.push_back(mk(260, 2'b10, 0));
    dir_q.push_back(16'h87D1);
    dir_q.push_back(16'hBE71);
    dir_q.push_back(16'h87D1);
    dir_q.push_back(16'h87D0);
    dir_q.push_back(mk(1300, 2'b10, 0));
    dir_q.push_back(mk(-400, 2'b10, 0));
    dir_q.push_back(mk(-401, 2'b10, 0));
    dir_q.push_back(mk(1023, 2'b01, 0));
    dir_q.push_back(mk(1023, 2'b10, 0));

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");

    // periodic acquisition: directed frames then random ones
    habilitar = 1'b1;
    wait_pulses(npulse + 13 + 15, 30000, "periodic_timeout");

    // habilitar dropped at bit 5: frame still reported, then idle
    wait_cs_fall(1100);
    wait_sclk_rises(5);
    habilitar  = 1'b0;
    chk_period = 1'b0;
    p0 = npulse;
    wait_pulses(p0 + 1, 300, "drop_report_timeout");
    repeat (2) @(negedge clk);
    chk("drop_cs_n", 32'(cs_n_o), 32'd1);
    f0 = nfall;
    repeat (1200) @(posedge clk);
    #1;
    chk("drop_no_restart", 32'(nfall), 32'(f0));
    chk("drop_cs_n_idle", 32'(cs_n_o), 32'd1);

    // reset at the 8th sclk rise aborts the frame silently
    habilitar = 1'b1;
    wait_cs_fall(10);
    wait_sclk_rises(8);
    rst       = 1'b1;
    habilitar = 1'b0;
    exp_q.delete();
    last_temp = 0;
    primed    = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_idle("abort");
    p0 = npulse;
    repeat (300) @(posedge clk);
    chk("abort_no_pulse", 32'(npulse), 32'(p0));

    // recovery after reset
    habilitar = 1'b1;
    wait_pulses(npulse + 2, 2500, "recover_timeout");
    habilitar = 1'b0;
    repeat (5) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
